// File: rtl/mesh_pkg.sv
// mesh_pkg
//   Shared definitions for the ADPLL mesh weight supervisor:
//   - supervisor state and mode encodings
//   - weight field positions inside one node's packed weight word
//   - default 2x2 acquire (uni-directional) and track (bi-directional) weight sets
//   - small helpers for error magnitude and field addressing
package mesh_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_RAMP    = 2'd2,
      ST_TRACK   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      MODE_AUTO   = 2'd0,
      MODE_UNI    = 2'd1,
      MODE_BI     = 2'd2,
      MODE_FREEZE = 2'd3
   } mode_t;

   // Each node word is {left, above, right, below}, below in the LSBs.
   localparam int FIELDS_PER_NODE = 4;
   localparam int FIELD_LEFT      = 3;
   localparam int FIELD_ABOVE     = 2;
   localparam int FIELD_RIGHT     = 1;
   localparam int FIELD_BELOW     = 0;

   localparam logic [63:0] UNI_DEFAULT = 64'h2200_0400_4000_4000;
   localparam logic [63:0] BI_DEFAULT  = 64'h2200_0220_2002_2011;

   // LSB position of one weight field in the packed weight vector.
   function automatic int field_lsb(input int node, input int field, input int w_width);
      return (node * FIELDS_PER_NODE + field) * w_width;
   endfunction

   // Magnitude of an already sign-extended error; the most negative error
   // code therefore yields 2^(PDET_WIDTH-1) rather than wrapping.
   function automatic int unsigned abs_err(input int signed e);
      if (e < 0) begin
         return int'(unsigned'(-e));
      end else begin
         return int'(unsigned'(e));
      end
   endfunction

endpackage

// File: rtl/lock_detector.sv
// lock_detector
//   Per-node lock qualifier with hysteresis. The error word is registered
//   first, so the counter reacts one cycle after a sample is presented.
//   Unlocked: consecutive |err| <= LOCK_TOL samples count up; LOCK_COUNT of
//   them set the flag. Locked: consecutive |err| > UNLOCK_TOL samples count up;
//   UNLOCK_COUNT of them clear the flag. Any other sample clears the counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear of sample, counter and flag
//   error      : signed phase error of this node
//   locked     : registered lock flag
module lock_detector
   import mesh_pkg::*;
#(
   parameter int PDET_WIDTH   = 5,
   parameter int LOCK_TOL     = 2,
   parameter int LOCK_COUNT   = 256,
   parameter int UNLOCK_TOL   = 6,
   parameter int UNLOCK_COUNT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic [PDET_WIDTH-1:0] error,
   output logic                  locked
);

   localparam int MW   = PDET_WIDTH + 1;
   localparam int CMAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [MW-1:0] LOCK_TOL_M   = MW'(LOCK_TOL);
   localparam logic [MW-1:0] UNLOCK_TOL_M = MW'(UNLOCK_TOL);
   localparam logic [CW-1:0] LOCK_LAST    = CW'(LOCK_COUNT - 1);
   localparam logic [CW-1:0] UNLOCK_LAST  = CW'(UNLOCK_COUNT - 1);

   logic signed [PDET_WIDTH-1:0] err_s;
   logic [MW-1:0]                mag_s;
   logic                         in_lock_s;
   logic                         out_lock_s;
   logic [CW-1:0]                cnt_n_s;
   logic                         locked_n_s;

   logic [MW-1:0]                mag_r;
   logic                         valid_r;
   logic [CW-1:0]                cnt_r;
   logic                         locked_r;

   assign err_s  = error;
   assign locked = locked_r;

   // Sign-extend the raw error and take its magnitude.
   always_comb begin
      mag_s = MW'(abs_err(int'(err_s)));
   end

   // Counter and flag update with hysteresis between the two tolerances.
   always_comb begin
      cnt_n_s    = cnt_r;
      locked_n_s = locked_r;
      in_lock_s  = (mag_r <= LOCK_TOL_M);
      out_lock_s = (mag_r > UNLOCK_TOL_M);
      if (!valid_r) begin
         // Sample register still holds a stale value after clear.
         cnt_n_s = '0;
      end else if (!locked_r) begin
         if (in_lock_s) begin
            if (cnt_r == LOCK_LAST) begin
               locked_n_s = 1'b1;
               cnt_n_s    = '0;
            end else begin
               cnt_n_s = cnt_r + CW'(1);
            end
         end else begin
            cnt_n_s = '0;
         end
      end else begin
         if (out_lock_s) begin
            if (cnt_r == UNLOCK_LAST) begin
               locked_n_s = 1'b0;
               cnt_n_s    = '0;
            end else begin
               cnt_n_s = cnt_r + CW'(1);
            end
         end else begin
            cnt_n_s = '0;
         end
      end
   end

   // Sample register, counter and lock flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_r    <= '0;
         valid_r  <= 1'b0;
         cnt_r    <= '0;
         locked_r <= 1'b0;
      end else if (clear) begin
         mag_r    <= '0;
         valid_r  <= 1'b0;
         cnt_r    <= '0;
         locked_r <= 1'b0;
      end else begin
         mag_r    <= mag_s;
         valid_r  <= 1'b1;
         cnt_r    <= cnt_n_s;
         locked_r <= locked_n_s;
      end
   end

endmodule

// File: rtl/mesh_weight_supervisor.sv
// mesh_weight_supervisor
//   Lock-driven weight scheduler for an N-node ADPLL mesh. Acquires on the
//   uni-directional weight set, ramps one LSB per RAMP_DIV cycles to the
//   bi-directional set once every node is locked, tracks there, and snaps
//   back to acquire weights when any node loses lock.
// Ports:
//   fpga_clk_i, rst_n_i : fast clock, asynchronous active-low reset
//   enable_i            : low forces IDLE and clears the lock detectors
//   mode_i              : 00 auto, 01 force uni, 10 force bi, 11 freeze
//   error_i             : per-node signed phase error, node 0 in LSBs
//   weights_o           : per-node {left,above,right,below} weights
//   node_locked_o       : per-node lock flags; all_locked_o is their AND
//   state_o             : 0 IDLE, 1 ACQUIRE, 2 RAMP, 3 TRACK
//   relock_count_o      : saturating count of fallbacks to ACQUIRE
//   timeout_o           : sticky ACQUIRE timeout flag
module mesh_weight_supervisor
   import mesh_pkg::*;
#(
   parameter int                          NODES        = 4,
   parameter int                          PDET_WIDTH   = 5,
   parameter int                          W_WIDTH      = 4,
   parameter logic [NODES*4*W_WIDTH-1:0]  UNI_WEIGHTS  = UNI_DEFAULT,
   parameter logic [NODES*4*W_WIDTH-1:0]  BI_WEIGHTS   = BI_DEFAULT,
   parameter int                          LOCK_TOL     = 2,
   parameter int                          LOCK_COUNT   = 256,
   parameter int                          UNLOCK_TOL   = 6,
   parameter int                          UNLOCK_COUNT = 16,
   parameter int                          RAMP_DIV     = 64,
   parameter int                          ACQ_TIMEOUT  = 65535
) (
   input  logic                          fpga_clk_i,
   input  logic                          rst_n_i,
   input  logic                          enable_i,
   input  logic [1:0]                    mode_i,
   input  logic [NODES*PDET_WIDTH-1:0]   error_i,
   output logic [NODES*4*W_WIDTH-1:0]    weights_o,
   output logic [NODES-1:0]              node_locked_o,
   output logic                          all_locked_o,
   output logic [1:0]                    state_o,
   output logic [7:0]                    relock_count_o,
   output logic                          timeout_o
);

   localparam int WW = NODES * FIELDS_PER_NODE * W_WIDTH;
   localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int TW = $clog2(ACQ_TIMEOUT + 1);

   localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
   localparam logic [TW-1:0] ACQ_LAST  = TW'(ACQ_TIMEOUT - 1);
   localparam logic [TW-1:0] ACQ_SAT   = TW'(ACQ_TIMEOUT);

   state_t          state_r;
   state_t          state_n_s;
   logic [WW-1:0]   weights_r;
   logic [WW-1:0]   weights_n_s;
   logic [WW-1:0]   stepped_s;
   logic [RW-1:0]   ramp_r;
   logic [RW-1:0]   ramp_n_s;
   logic [TW-1:0]   tcnt_r;
   logic [TW-1:0]   tcnt_n_s;
   logic            timeout_r;
   logic            timeout_n_s;
   logic [7:0]      relock_r;
   logic [7:0]      relock_n_s;
   logic            relock_inc_s;
   logic            clear_s;
   logic [NODES-1:0] locked_s;
   logic            all_locked_s;

   assign clear_s      = ~enable_i;
   assign all_locked_s = &locked_s;

   for (genvar n = 0; n < NODES; n++) begin : g_node
      lock_detector #(
         .PDET_WIDTH   (PDET_WIDTH),
         .LOCK_TOL     (LOCK_TOL),
         .LOCK_COUNT   (LOCK_COUNT),
         .UNLOCK_TOL   (UNLOCK_TOL),
         .UNLOCK_COUNT (UNLOCK_COUNT)
      ) u_det (
         .clk    (fpga_clk_i),
         .rst_n  (rst_n_i),
         .clear  (clear_s),
         .error  (error_i[n*PDET_WIDTH +: PDET_WIDTH]),
         .locked (locked_s[n])
      );
   end

   // One ramp step: every field moves one LSB toward its track value.
   always_comb begin
      stepped_s = weights_r;
      for (int n = 0; n < NODES; n++) begin
         for (int f = 0; f < FIELDS_PER_NODE; f++) begin
            if (weights_r[field_lsb(n, f, W_WIDTH) +: W_WIDTH] <
                BI_WEIGHTS[field_lsb(n, f, W_WIDTH) +: W_WIDTH]) begin
               stepped_s[field_lsb(n, f, W_WIDTH) +: W_WIDTH] =
                  weights_r[field_lsb(n, f, W_WIDTH) +: W_WIDTH] + W_WIDTH'(1);
            end else if (weights_r[field_lsb(n, f, W_WIDTH) +: W_WIDTH] >
                         BI_WEIGHTS[field_lsb(n, f, W_WIDTH) +: W_WIDTH]) begin
               stepped_s[field_lsb(n, f, W_WIDTH) +: W_WIDTH] =
                  weights_r[field_lsb(n, f, W_WIDTH) +: W_WIDTH] - W_WIDTH'(1);
            end else begin
               stepped_s[field_lsb(n, f, W_WIDTH) +: W_WIDTH] =
                  weights_r[field_lsb(n, f, W_WIDTH) +: W_WIDTH];
            end
         end
      end
   end

   // Next state, next weights and ramp pacing; enable low overrides all.
   always_comb begin
      state_n_s    = state_r;
      weights_n_s  = weights_r;
      ramp_n_s     = '0;
      relock_inc_s = 1'b0;
      if (!enable_i) begin
         state_n_s   = ST_IDLE;
         weights_n_s = UNI_WEIGHTS;
      end else begin
         case (mode_i)
            MODE_FREEZE: begin
               state_n_s   = state_r;
               weights_n_s = weights_r;
               ramp_n_s    = ramp_r;
            end
            MODE_UNI: begin
               state_n_s   = ST_ACQUIRE;
               weights_n_s = UNI_WEIGHTS;
            end
            MODE_BI: begin
               state_n_s   = ST_TRACK;
               weights_n_s = BI_WEIGHTS;
            end
            default: begin
               case (state_r)
                  ST_IDLE: begin
                     state_n_s   = ST_ACQUIRE;
                     weights_n_s = UNI_WEIGHTS;
                  end
                  ST_ACQUIRE: begin
                     weights_n_s = UNI_WEIGHTS;
                     if (all_locked_s) begin
                        state_n_s = ST_RAMP;
                     end else begin
                        state_n_s = ST_ACQUIRE;
                     end
                  end
                  ST_RAMP: begin
                     // Lock loss wins over a ramp that completes this cycle.
                     if (!all_locked_s) begin
                        state_n_s    = ST_ACQUIRE;
                        weights_n_s  = UNI_WEIGHTS;
                        relock_inc_s = 1'b1;
                     end else if (weights_r == BI_WEIGHTS) begin
                        state_n_s = ST_TRACK;
                     end else if (ramp_r == RAMP_LAST) begin
                        weights_n_s = stepped_s;
                     end else begin
                        ramp_n_s = ramp_r + RW'(1);
                     end
                  end
                  ST_TRACK: begin
                     weights_n_s = BI_WEIGHTS;
                     if (!all_locked_s) begin
                        state_n_s    = ST_ACQUIRE;
                        weights_n_s  = UNI_WEIGHTS;
                        relock_inc_s = 1'b1;
                     end else begin
                        state_n_s = ST_TRACK;
                     end
                  end
                  default: begin
                     state_n_s   = ST_IDLE;
                     weights_n_s = UNI_WEIGHTS;
                  end
               endcase
            end
         endcase
      end
   end

   // Acquire timeout counter, sticky flag and saturating relock count.
   always_comb begin
      tcnt_n_s    = '0;
      timeout_n_s = timeout_r;
      relock_n_s  = relock_r;
      if (state_r == ST_ACQUIRE) begin
         if (tcnt_r == ACQ_SAT) begin
            tcnt_n_s = tcnt_r;
         end else begin
            tcnt_n_s = tcnt_r + TW'(1);
         end
         if (tcnt_r == ACQ_LAST) begin
            timeout_n_s = 1'b1;
         end else begin
            timeout_n_s = timeout_r;
         end
      end else begin
         tcnt_n_s = '0;
      end
      // A successful arrival in TRACK retires an earlier timeout.
      if ((state_n_s == ST_TRACK) && (state_r != ST_TRACK)) begin
         timeout_n_s = 1'b0;
      end else begin
         timeout_n_s = timeout_n_s;
      end
      if (relock_inc_s && (relock_r != 8'hFF)) begin
         relock_n_s = relock_r + 8'd1;
      end else begin
         relock_n_s = relock_r;
      end
   end

   // Supervisor state registers.
   always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r   <= ST_IDLE;
         weights_r <= UNI_WEIGHTS;
         ramp_r    <= '0;
         tcnt_r    <= '0;
         timeout_r <= 1'b0;
         relock_r  <= 8'd0;
      end else begin
         state_r   <= state_n_s;
         weights_r <= weights_n_s;
         ramp_r    <= ramp_n_s;
         tcnt_r    <= tcnt_n_s;
         timeout_r <= timeout_n_s;
         relock_r  <= relock_n_s;
      end
   end

   assign weights_o      = weights_r;
   assign node_locked_o  = locked_s;
   assign all_locked_o   = all_locked_s;
   assign state_o        = state_r;
   assign relock_count_o = relock_r;
   assign timeout_o      = timeout_r;

endmodule
